reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Write-side companion of reg_file. Sole driver of its single write port (we3/a3/wd3).
- Merges two result sources onto that port:
  - single-cycle ALU results, which have no backpressure;
  - multi-cycle load results, which use a valid/ready handshake and a small buffer.
- Keeps a pending-write scoreboard so the decode stage can stall on load-use hazards.

Parameters:
- LD_DEPTH, 2, number of entries in the load-result buffer (power of two, ≥2).
- XLEN, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  buffer can accept a load result.
- ld_rd  in  5  load destination register.
- ld_data  in  XLEN  load result.
- iss_valid  in  1  a load is issued this cycle; marks iss_rd pending.
- iss_rd  in  5  destination register of the issued load.
- chk_rs1  in  5  decode source register 1.
- chk_rs2  in  5  decode source register 2.
- chk_stall  out  1  chk_rs1 or chk_rs2 has a pending load write.
- we3  out  1  reg_file write enable.
- a3  out  5  reg_file write address.
- wd3  out  XLEN  reg_file write data.

Behaviour:
- Reset, asynchronous on rst_n low:
  - we3=0, a3=0, wd3=0;
  - buffer empty, pending bitmap all zero;
  - ld_ready=1, chk_stall=0.
- Reset asserted mid-operation discards all buffered loads and all pending bits.
- Load handshake:
  - Transfer occurs when ld_valid && ld_ready. The {ld_rd, ld_data} pair is pushed into the FIFO.
  - ld_ready = !full, with no dependence on ld_valid.
  - When the buffer is full, no push is accepted even if a pop happens in the same cycle.
- Write-port arbitration each cycle, with registered outputs (1-cycle latency):
  - alu_valid=1: next we3=(alu_rd!=0), a3=alu_rd, wd3=alu_data. The buffer does not pop.
  - Else, buffer non-empty: pop the head; next we3=(head_rd!=0), a3=head_rd, wd3=head_data.
  - Else: next we3=0; a3 and wd3 hold their previous values.
- ALU priority is absolute. A continuous ALU stream starves the buffer, and the upstream pipeline is responsible for leaving bubbles.
- x0: any write to rd=0 is consumed (it pops the buffer or uses the ALU slot) with we3=0.
- Scoreboard (pending[31:0]):
  - Set pending[iss_rd] on iss_valid when iss_rd!=0.
  - Clear pending[head_rd] in the cycle the buffer pops toward we3.
  - Same register set and cleared in the same cycle: set wins.
  - pending[0] is always 0.
  - ALU writes never change pending.
- chk_stall = pending[chk_rs1] | pending[chk_rs2], combinational from registered state.
- A load whose result is accepted but not yet written keeps its register pending until the pop cycle.
- FIFO pointers are log2(LD_DEPTH)+1 bits wide and wrap modulo 2*LD_DEPTH. Full is defined as MSBs differ and low bits equal.

Optional Feature:
- Macro: REG_WB_BYPASS_EN.
- Defined: adds outputs fwd1_hit, fwd2_hit (1 bit each) and fwd1_data, fwd2_data (XLEN each).
  - fwdN_hit = we3 && a3!=0 && a3==chk_rsN.
  - fwdN_data = wd3.
  - The decode stage uses these to bypass the same-cycle reg_file write.
- Not defined: these ports do not exist, and reg_file's own timing must cover write-then-read.

Decomposition:
- Package reg_wb_pkg holds:
  - constants REG_AW=5, ZERO_REG=5'd0;
  - typedef wb_entry_t {logic[4:0] rd; logic[XLEN-1:0] data;}.
- One sub-module, wb_fifo: a parametric synchronous FIFO of wb_entry_t with push, pop, full, empty and head outputs. Arbitration and scoreboard stay in reg_wb_arbiter.

Test Plan:
- Reset then idle 5 cycles -> we3=0, a3=0, wd3=0, ld_ready=1, chk_stall=0 throughout.
- alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF for 1 cycle -> next cycle we3=1, a3=5, wd3=DEADBEEF; reading x5 afterward returns DEADBEEF.
- iss_valid with iss_rd=7, then chk_rs1=7 -> chk_stall=1. Push ld {7, 32'h12345678} -> write appears 1 cycle after the push with chk_stall=0 the same cycle.
- ALU valid for 4 cycles while loads {3,0xA} and {4,0xB} are pushed:
  - ld_ready drops after 2 pushes (LD_DEPTH=2);
  - loads write x3 then x4 in the two cycles after the ALU stream ends.
- alu_rd=0 with data 0xFFFFFFFF, and load rd=0 -> we3 stays 0 and the buffer empties.
- rst_n pulled low with 2 loads buffered and pending[9]=1 -> buffer empty, chk_stall=0 for rs=9, and no write of the buffered data after release.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register-file write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_wb_pkg;

   // Width of the data field carried in a buffered load result.
   // The arbiter's XLEN parameter must match this value.
   localparam int WB_XLEN = 32;

   localparam int REG_AW = 5;
   localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

   // One pending load result: destination register and value.
   typedef struct packed {
      logic [REG_AW-1:0]  rd;
      logic [WB_XLEN-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_entry_t holding load results waiting for the write port.
// Latency: a pushed entry is visible on head the cycle after the push.
// Backpressure: full blocks push even when a pop happens in the same cycle.
module wb_fifo
   import reg_wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  wb_entry_t din,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output wb_entry_t head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   wb_entry_t   mem [DEPTH];
   logic        push_ok;
   logic        pop_ok;

   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   // Pointer update; reset empties the buffer and drops its contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Sole driver of reg_file's write port: merges ALU and buffered load results,
// tracks pending load writes. Latency: 1 cycle to we3/a3/wd3. Backpressure: ALU
// never stalled; loads use ld_ready = !full. Optional: REG_WB_BYPASS_EN adds fwd ports.
module reg_wb_arbiter
   import reg_wb_pkg::*;
#(
   parameter int LD_DEPTH = 2,
   parameter int XLEN     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   input  logic [4:0]        alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [4:0]        ld_rd,
   input  logic [XLEN-1:0]   ld_data,
   input  logic              iss_valid,
   input  logic [4:0]        iss_rd,
   input  logic [4:0]        chk_rs1,
   input  logic [4:0]        chk_rs2,
   output logic              chk_stall,
`ifdef REG_WB_BYPASS_EN
   output logic              fwd1_hit,
   output logic              fwd2_hit,
   output logic [XLEN-1:0]   fwd1_data,
   output logic [XLEN-1:0]   fwd2_data,
`endif
   output logic              we3,
   output logic [4:0]        a3,
   output logic [XLEN-1:0]   wd3
);

   logic      fifo_full;
   logic      fifo_empty;
   logic      push;
   logic      pop;
   wb_entry_t ld_entry;
   wb_entry_t head;
   logic [31:0] pending;
   logic [31:0] pending_nxt;

   // A load is accepted whenever there is room; ALU results always win the port.
   assign ld_ready       = !fifo_full;
   assign push           = ld_valid && !fifo_full;
   assign pop            = !alu_valid && !fifo_empty;
   assign ld_entry.rd    = ld_rd;
   assign ld_entry.data  = ld_data;

   wb_fifo #(
      .DEPTH (LD_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (ld_entry),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head)
   );

   // Write-port arbitration; writes to x0 still consume their slot but keep we3 low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we3 <= 1'b0;
         a3  <= '0;
         wd3 <= '0;
      end else if (alu_valid) begin
         we3 <= (alu_rd != ZERO_REG);
         a3  <= alu_rd;
         wd3 <= alu_data;
      end else if (pop) begin
         we3 <= (head.rd != ZERO_REG);
         a3  <= head.rd;
         wd3 <= head.data;
      end else begin
         we3 <= 1'b0;
      end
   end

   // Scoreboard next state: clear on pop first so a same-cycle issue re-sets the bit.
   always_comb begin
      pending_nxt = pending;
      if (pop && (head.rd != ZERO_REG)) pending_nxt[head.rd] = 1'b0;
      if (iss_valid && (iss_rd != ZERO_REG)) pending_nxt[iss_rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Scoreboard register; reset drops every outstanding load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= pending_nxt;
   end

   assign chk_stall = pending[chk_rs1] | pending[chk_rs2];

`ifdef REG_WB_BYPASS_EN
   // Same-cycle bypass of the write currently being presented to reg_file.
   assign fwd1_hit  = we3 && (a3 != ZERO_REG) && (a3 == chk_rs1);
   assign fwd2_hit  = we3 && (a3 != ZERO_REG) && (a3 == chk_rs2);
   assign fwd1_data = wd3;
   assign fwd2_data = wd3;
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios then random traffic.
// Latency: expects registered write port one cycle after the deciding edge.
// Backpressure: models a LD_DEPTH-entry load queue with no push when full.
module tb_reg_wb_arbiter;

   localparam int LD_DEPTH = 2;
   localparam int XLEN     = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            alu_valid = 1'b0;
   logic [4:0]      alu_rd = '0;
   logic [XLEN-1:0] alu_data = '0;
   logic            ld_valid = 1'b0;
   logic            ld_ready;
   logic [4:0]      ld_rd = '0;
   logic [XLEN-1:0] ld_data = '0;
   logic            iss_valid = 1'b0;
   logic [4:0]      iss_rd = '0;
   logic [4:0]      chk_rs1 = '0;
   logic [4:0]      chk_rs2 = '0;
   logic            chk_stall;
   logic            we3;
   logic [4:0]      a3;
   logic [XLEN-1:0] wd3;
`ifdef REG_WB_BYPASS_EN
   logic            fwd1_hit;
   logic            fwd2_hit;
   logic [XLEN-1:0] fwd1_data;
   logic [XLEN-1:0] fwd2_data;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: a queue of outstanding load results plus a pending set.
   bit [4:0]  q_rd [$];
   bit [31:0] q_dat [$];
   bit [31:0] m_pend;
   bit        m_we;
   bit [4:0]  m_a3;
   bit [31:0] m_wd;

   reg_wb_arbiter #(
      .LD_DEPTH (LD_DEPTH),
      .XLEN     (XLEN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_rd     (ld_rd),
      .ld_data   (ld_data),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .chk_rs1   (chk_rs1),
      .chk_rs2   (chk_rs2),
      .chk_stall (chk_stall),
`ifdef REG_WB_BYPASS_EN
      .fwd1_hit  (fwd1_hit),
      .fwd2_hit  (fwd2_hit),
      .fwd1_data (fwd1_data),
      .fwd2_data (fwd2_data),
`endif
      .we3       (we3),
      .a3        (a3),
      .wd3       (wd3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q_rd.delete();
      q_dat.delete();
      m_pend = '0;
      m_we   = 1'b0;
      m_a3   = '0;
      m_wd   = '0;
   endtask

   // Compare every DUT output with the model for the current inputs.
   task automatic check_state(input string where);
      chk({where, ".we3"},       {31'd0, we3},      {31'd0, m_we});
      chk({where, ".a3"},        {27'd0, a3},       {27'd0, m_a3});
      chk({where, ".wd3"},       wd3,               m_wd);
      chk({where, ".ld_ready"},  {31'd0, ld_ready}, {31'd0, (q_rd.size() < LD_DEPTH)});
      chk({where, ".chk_stall"}, {31'd0, chk_stall},
          {31'd0, (m_pend[chk_rs1] | m_pend[chk_rs2])});
`ifdef REG_WB_BYPASS_EN
      chk({where, ".fwd1_hit"}, {31'd0, fwd1_hit},
          {31'd0, (m_we && m_a3 != 0 && m_a3 == chk_rs1)});
      chk({where, ".fwd2_hit"}, {31'd0, fwd2_hit},
          {31'd0, (m_we && m_a3 != 0 && m_a3 == chk_rs2)});
      chk({where, ".fwd1_data"}, fwd1_data, m_wd);
      chk({where, ".fwd2_data"}, fwd2_data, m_wd);
`endif
   endtask

   // One clock: decide from pre-edge model state, advance the model, compare.
   task automatic step(input string where);
      bit        rdy;
      bit        do_pop;
      bit [4:0]  h_rd;
      bit [31:0] h_dat;
      rdy    = (q_rd.size() < LD_DEPTH);
      do_pop = !alu_valid && (q_rd.size() != 0);
      @(posedge clk);
      #1;
      if (alu_valid) begin
         m_we = (alu_rd != 0);
         m_a3 = alu_rd;
         m_wd = alu_data;
      end else if (do_pop) begin
         h_rd  = q_rd.pop_front();
         h_dat = q_dat.pop_front();
         m_we  = (h_rd != 0);
         m_a3  = h_rd;
         m_wd  = h_dat;
         m_pend[h_rd] = 1'b0;
      end else begin
         m_we = 1'b0;
      end
      if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
      m_pend[0] = 1'b0;
      if (ld_valid && rdy) begin
         q_rd.push_back(ld_rd);
         q_dat.push_back(ld_data);
      end
      check_state(where);
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      iss_valid = 1'b0;
   endtask

   task automatic async_reset(input string where);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_state(where);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset and idle.
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_state("rst");
      chk("rst_we3", {31'd0, we3}, 32'd0);
      chk("rst_wd3", wd3, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step("idle");
         chk("idle_ready", {31'd0, ld_ready}, 32'd1);
         chk("idle_stall", {31'd0, chk_stall}, 32'd0);
      end

      // Single ALU write.
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      step("alu");
      alu_valid = 1'b0;
      chk("alu_we3", {31'd0, we3}, 32'd1);
      chk("alu_a3", {27'd0, a3}, 32'd5);
      chk("alu_wd3", wd3, 32'hDEADBEEF);
      step("alu_after");

      // Load-use hazard on x7.
      iss_valid = 1'b1; iss_rd = 5'd7;
      step("iss7");
      iss_valid = 1'b0; chk_rs1 = 5'd7;
      #1;
      chk("lu_stall_set", {31'd0, chk_stall}, 32'd1);
      ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h12345678;
      step("ld7_push");
      ld_valid = 1'b0;
      chk("lu_stall_buffered", {31'd0, chk_stall}, 32'd1);
      step("ld7_write");
      chk("ld7_we3", {31'd0, we3}, 32'd1);
      chk("ld7_a3", {27'd0, a3}, 32'd7);
      chk("ld7_wd3", wd3, 32'h12345678);
      chk("ld7_stall_clear", {31'd0, chk_stall}, 32'd0);
      chk_rs1 = 5'd0;

      // ALU stream starves the buffer; a third load is refused while full.
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'(i);
         ld_valid  = 1'b1;
         ld_rd     = (i == 0) ? 5'd3 : (i == 1) ? 5'd4 : 5'd6;
         ld_data   = (i == 0) ? 32'hA : (i == 1) ? 32'hB : 32'hC;
         step("stream");
         if (i == 1) chk("stream_full", {31'd0, ld_ready}, 32'd0);
      end
      idle_inputs();
      step("drain0");
      chk("drain0_a3", {27'd0, a3}, 32'd3);
      chk("drain0_wd3", wd3, 32'hA);
      step("drain1");
      chk("drain1_a3", {27'd0, a3}, 32'd4);
      chk("drain1_wd3", wd3, 32'hB);
      step("drain2");
      chk("drain2_we3", {31'd0, we3}, 32'd0);

      // Writes to x0 consume their slot without enabling the port.
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
      ld_valid  = 1'b1; ld_rd  = 5'd0; ld_data  = 32'h55;
      step("x0_alu");
      chk("x0_alu_we3", {31'd0, we3}, 32'd0);
      idle_inputs();
      step("x0_ld");
      chk("x0_ld_we3", {31'd0, we3}, 32'd0);
      step("x0_empty");
      chk("x0_empty_ready", {31'd0, ld_ready}, 32'd1);

      // Reset with two loads buffered and x9 pending.
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
      iss_valid = 1'b1; iss_rd = 5'd9;
      ld_valid  = 1'b1; ld_rd  = 5'd9; ld_data = 32'h99;
      step("mr_push0");
      iss_valid = 1'b0; ld_rd = 5'd2; ld_data = 32'h22;
      step("mr_push1");
      ld_valid = 1'b0; chk_rs1 = 5'd9;
      #1;
      chk("mr_full", {31'd0, ld_ready}, 32'd0);
      chk("mr_stall", {31'd0, chk_stall}, 32'd1);
      alu_valid = 1'b0;
      async_reset("mr_rst");
      chk("mr_rst_stall", {31'd0, chk_stall}, 32'd0);
      chk("mr_rst_ready", {31'd0, ld_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step("mr_after");
         chk("mr_after_we3", {31'd0, we3}, 32'd0);
      end

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         alu_valid = ($urandom_range(0, 9) < 4);
         alu_rd    = 5'($urandom_range(0, 7));
         alu_data  = $urandom;
         ld_valid  = ($urandom_range(0, 9) < 6);
         ld_rd     = 5'($urandom_range(0, 7));
         ld_data   = $urandom;
         iss_valid = ($urandom_range(0, 9) < 3);
         iss_rd    = 5'($urandom_range(0, 7));
         chk_rs1   = 5'($urandom_range(0, 7));
         chk_rs2   = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
         step("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
